// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// fields, datapath select codes and the decoded-instruction record.
package mips_defs;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BR     = 3'd5,
        S_JMP    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_RALU,
        CLS_IALU,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_JMP,
        CLS_ILL
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_LUI = 4'b0111;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JUMP = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_LUI  = 2'b01;
    localparam logic [1:0] EXT_ZERO = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    typedef struct packed {
        cls_t       cls;
        logic       is_bne;
        logic       is_jal;
        logic       is_jr;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [3:0] alu_ctr;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: instruction class, ALU operation,
// immediate extension and operand-B select from the raw instruction word.
module mc_decode
    import mips_defs::*;
(
    input  logic [31:0] Instr,
    output dec_t        dec
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = Instr[31:26];
    assign funct = Instr[5:0];

    always_comb begin
        dec     = '0;
        dec.cls = CLS_ILL;
        // The all-zero word is the canonical nop; other sll forms are real writes.
        if (Instr == 32'd0) begin
            dec.cls = CLS_NOP;
        end else begin
            case (op)
                OP_RTYPE: begin
                    dec.cls = CLS_RALU;
                    case (funct)
                        FN_ADD, FN_ADDU: dec.alu_ctr = ALU_ADD;
                        FN_SUB, FN_SUBU: dec.alu_ctr = ALU_SUB;
                        FN_AND:          dec.alu_ctr = ALU_AND;
                        FN_OR:           dec.alu_ctr = ALU_OR;
                        FN_XOR:          dec.alu_ctr = ALU_XOR;
                        FN_SLL:          dec.alu_ctr = ALU_SLL;
                        FN_SRL:          dec.alu_ctr = ALU_SRL;
                        FN_JR: begin
                            dec.cls   = CLS_JMP;
                            dec.is_jr = 1'b1;
                        end
                        default:         dec.cls = CLS_ILL;
                    endcase
                end
                OP_ADDI, OP_ADDIU: begin
                    dec.cls     = CLS_IALU;
                    dec.alu_src = 1'b1;
                end
                OP_ORI: begin
                    dec.cls     = CLS_IALU;
                    dec.alu_src = 1'b1;
                    dec.alu_ctr = ALU_OR;
                    dec.ext_op  = EXT_ZERO;
                end
                OP_LUI: begin
                    dec.cls     = CLS_IALU;
                    dec.alu_src = 1'b1;
                    dec.alu_ctr = ALU_LUI;
                    dec.ext_op  = EXT_LUI;
                end
                OP_LW: begin
                    dec.cls     = CLS_LW;
                    dec.alu_src = 1'b1;
                end
                OP_SW: begin
                    dec.cls     = CLS_SW;
                    dec.alu_src = 1'b1;
                end
                OP_BEQ: dec.cls = CLS_BR;
                OP_BNE: begin
                    dec.cls    = CLS_BR;
                    dec.is_bne = 1'b1;
                end
                OP_J:   dec.cls = CLS_JMP;
                OP_JAL: begin
                    dec.cls    = CLS_JMP;
                    dec.is_jal = 1'b1;
                end
                default: dec.cls = CLS_ILL;
            endcase
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with bounded memory waits, a retired-instruction
// counter and single-cycle illegal / bus-error pulses.
module mc_controller
    import mips_defs::*;
#(
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic             Zero,
    input  logic             mem_rdy,
    output logic             mem_req,
    output logic             IRWr,
    output logic             PCWr,
    output logic             RegWr,
    output logic             MemWr,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ExtOp,
    output logic [1:0]       NPCOp,
    output logic             ALUSrc,
    output logic [3:0]       ALUCtr,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             bus_err
);

    localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [WCNT_W-1:0]  wait_cnt_reg;
    logic [WCNT_W-1:0]  wait_cnt_next;
    logic [CNT_W-1:0]   retired_reg;
    logic [CNT_W-1:0]   retired_next;
    dec_t               dec;
    logic               mem_phase;
    logic               timeout;
    logic               retire;

    mc_decode u_decode (
        .Instr (Instr),
        .dec   (dec)
    );

    // A completing strobe on the last allowed cycle wins over the timeout.
    assign mem_phase = (state_reg == S_FETCH) || (state_reg == S_MEM);
    assign timeout   = mem_phase && !mem_rdy && (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            retired_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            retired_reg  <= retired_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        retire        = 1'b0;
        wait_cnt_next = (mem_phase && !mem_rdy && !timeout) ? wait_cnt_reg + WCNT_W'(1) : '0;
        case (state_reg)
            S_FETCH: begin
                if (mem_rdy)      state_next = S_DECODE;
                else if (timeout) state_next = S_FETCH;
            end
            S_DECODE: begin
                case (dec.cls)
                    CLS_RALU, CLS_IALU, CLS_LW, CLS_SW: state_next = S_EXE;
                    CLS_BR:  state_next = S_BR;
                    CLS_JMP: state_next = S_JMP;
                    default: state_next = S_FETCH;
                endcase
                retire = (dec.cls == CLS_NOP);
            end
            S_EXE: state_next = (dec.cls == CLS_LW || dec.cls == CLS_SW) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_rdy) begin
                    state_next = (dec.cls == CLS_LW) ? S_WB : S_FETCH;
                    retire     = (dec.cls == CLS_SW);
                end else if (timeout) begin
                    state_next = S_FETCH;
                end
            end
            S_WB, S_BR, S_JMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
        retired_next = retire ? retired_reg + CNT_W'(1) : retired_reg;
    end

    always_comb begin
        mem_req  = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        RegDst   = DST_RT;
        MemtoReg = M2R_ALU;
        ExtOp    = EXT_SIGN;
        NPCOp    = NPC_PC4;
        ALUSrc   = 1'b0;
        ALUCtr   = ALU_ADD;
        illegal  = 1'b0;
        bus_err  = timeout;
        case (state_reg)
            S_FETCH: begin
                mem_req = 1'b1;
                IRWr    = mem_rdy;
                PCWr    = mem_rdy;
            end
            S_DECODE: illegal = (dec.cls == CLS_ILL);
            S_EXE: begin
                ALUSrc = dec.alu_src;
                ALUCtr = dec.alu_ctr;
                ExtOp  = dec.ext_op;
            end
            S_MEM: begin
                mem_req = 1'b1;
                MemWr   = (dec.cls == CLS_SW) && !timeout;
            end
            S_WB: begin
                RegWr    = 1'b1;
                RegDst   = (dec.cls == CLS_RALU) ? DST_RD : DST_RT;
                MemtoReg = (dec.cls == CLS_LW) ? M2R_MEM : M2R_ALU;
            end
            S_BR: begin
                PCWr  = Zero ^ dec.is_bne;
                NPCOp = NPC_BR;
            end
            S_JMP: begin
                PCWr  = 1'b1;
                NPCOp = dec.is_jr ? NPC_JR : NPC_JUMP;
                if (dec.is_jal) begin
                    RegWr    = 1'b1;
                    RegDst   = DST_RA;
                    MemtoReg = M2R_PC;
                end
            end
            default: ;
        endcase
        // Reset silences every side effect even before the state register clears.
        if (reset) begin
            mem_req = 1'b0;
            IRWr    = 1'b0;
            PCWr    = 1'b0;
            RegWr   = 1'b0;
            MemWr   = 1'b0;
            illegal = 1'b0;
            bus_err = 1'b0;
        end
    end

    assign state   = state_reg;
    assign retired = retired_reg;

endmodule
